// File: rtl/matrix_fetch_unit_if.sv
// rtl/matrix_fetch_unit_if.sv - read request/response and preload bus of the matrix fetch unit
// master = matrix-multiplier controller side, slave = fetch unit side.
interface matrix_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  init_we;
  logic                  init_sel;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] init_data;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  data_valid;

  modport master (
    output read_en, rom_address, ram_address,
    output init_we, init_sel, init_addr, init_data,
    input  a_data, b_data, data_valid
  );

  modport slave (
    input  read_en, rom_address, ram_address,
    input  init_we, init_sel, init_addr, init_data,
    output a_data, b_data, data_valid
  );
endinterface

// File: rtl/matrix_fetch_unit.sv
// rtl/matrix_fetch_unit.sv - serves A/B element reads from two local memories and packs them into an operand bank
// Optional macro FETCH_ERR_EN enables the sticky fetch_err protocol error flag.
module matrix_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAT_DIM    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  matrix_fetch_unit_if.slave                    bus,
  input  logic                                  consume,
  output logic [$clog2(MAT_DIM*MAT_DIM):0]      elem_count,
  output logic                                  bank_full,
  output logic [MAT_DIM*MAT_DIM*DATA_WIDTH-1:0] a_bank,
  output logic [MAT_DIM*MAT_DIM*DATA_WIDTH-1:0] b_bank,
  output logic                                  fetch_err
);
  localparam int TOTAL = MAT_DIM * MAT_DIM;
  localparam int CW    = $clog2(TOTAL) + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] rom_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] ram_mem [0:DEPTH-1];

  // The element arriving this cycle completes the bank; a request now would overflow it.
  logic last_return;
  assign last_return = bus.data_valid && (elem_count == CW'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!reset && enable && bus.init_we) begin
      if (bus.init_sel) ram_mem[bus.init_addr] <= bus.init_data;
      else              rom_mem[bus.init_addr] <= bus.init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bus.a_data     <= '0;
      bus.b_data     <= '0;
      bus.data_valid <= 1'b0;
      elem_count     <= '0;
      bank_full      <= 1'b0;
      a_bank         <= '0;
      b_bank         <= '0;
    end else if (enable) begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read_en) begin
            bus.a_data     <= rom_mem[bus.rom_address];
            bus.b_data     <= ram_mem[bus.ram_address];
            bus.data_valid <= 1'b1;
            state          <= FILL;
          end
        end
        FILL: begin
          if (bus.data_valid) begin
            for (int i = 0; i < TOTAL; i++) begin
              if (elem_count == CW'(i)) begin
                a_bank[i*DATA_WIDTH +: DATA_WIDTH] <= bus.a_data;
                b_bank[i*DATA_WIDTH +: DATA_WIDTH] <= bus.b_data;
              end
            end
            elem_count <= elem_count + 1'b1;
            if (last_return) begin
              state     <= FULL;
              bank_full <= 1'b1;
            end
          end
          if (bus.read_en && !last_return) begin
            bus.a_data     <= rom_mem[bus.rom_address];
            bus.b_data     <= ram_mem[bus.ram_address];
            bus.data_valid <= 1'b1;
          end
        end
        FULL: begin
          if (consume) begin
            state      <= IDLE;
            bank_full  <= 1'b0;
            elem_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else if (enable) begin
      if ((state == FULL && bus.read_en) || (state != FULL && consume))
        fetch_err <= 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_fetch_unit.sv
// tb/tb_matrix_fetch_unit.sv - scoreboard bench for matrix_fetch_unit
// Honours FETCH_ERR_EN for the expected fetch_err value.
module tb_matrix_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

`ifdef FETCH_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          consume = 1'b0;
  logic [4:0]    elem_count;
  logic          bank_full;
  logic          fetch_err;
  logic [N*DW-1:0] a_bank;
  logic [N*DW-1:0] b_bank;

  matrix_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  matrix_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAT_DIM(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus_if),
    .consume    (consume),
    .elem_count (elem_count),
    .bank_full  (bank_full),
    .a_bank     (a_bank),
    .b_bank     (b_bank),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [63:0] sb[$];
  logic [31:0] rom_m [N];
  logic [31:0] ram_m [N];
  logic [31:0] exp_a [N];
  logic [31:0] exp_b [N];
  int slot = 0;

  // Returned pairs are taken only when the pipeline is advancing.
  always @(negedge clk) begin
    if (!reset && enable && bus_if.data_valid) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_data: got a=%h b=%h, required no data_valid", bus_if.a_data, bus_if.b_data);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({bus_if.a_data, bus_if.b_data} !== e) begin
          mismatched++;
          $display("FAIL read_data: got a=%h b=%h, required a=%h b=%h",
                   bus_if.a_data, bus_if.b_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus_if.read_en = 1'b0;
    bus_if.rom_address = '0;
    bus_if.ram_address = '0;
    bus_if.init_we = 1'b0;
    bus_if.init_sel = 1'b0;
    bus_if.init_addr = '0;
    bus_if.init_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.read_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    slot = 0;
  endtask

  task automatic req(input int ra, input int rb);
    bus_if.read_en = 1'b1;
    bus_if.rom_address = ra[3:0];
    bus_if.ram_address = rb[3:0];
    sb.push_back({rom_m[ra], ram_m[rb]});
    if (slot < N) begin
      exp_a[slot] = rom_m[ra];
      exp_b[slot] = ram_m[rb];
    end
    slot++;
    tick();
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      rom_m[i] = 32'h100 + i;
      ram_m[i] = 32'h200 + i;
      bus_if.init_we = 1'b1;
      bus_if.init_sel = 1'b0;
      bus_if.init_addr = i[3:0];
      bus_if.init_data = rom_m[i];
      tick();
      bus_if.init_sel = 1'b1;
      bus_if.init_data = ram_m[i];
      tick();
    end
    bus_if.init_we = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    do_reset();
    compared++;
    if ({bus_if.a_data, bus_if.b_data, bus_if.data_valid, elem_count, bank_full, fetch_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_scalars: got a=%h b=%h dv=%b cnt=%0d full=%b err=%b, required all 0",
               bus_if.a_data, bus_if.b_data, bus_if.data_valid, elem_count, bank_full, fetch_err);
    end
    compared++;
    if (a_bank !== '0 || b_bank !== '0) begin
      mismatched++;
      $display("FAIL reset_banks: got nonzero bank, required 0");
    end
  endtask

  task automatic test_full_fill();
    do_reset();
    for (int i = 0; i < N; i++) req(i, i);
    compared++;
    if (elem_count !== 5'd15 || bank_full !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_full: got cnt=%0d full=%b, required cnt=15 full=0", elem_count, bank_full);
    end
    bus_if.read_en = 1'b1;
    bus_if.rom_address = 4'd0;
    bus_if.ram_address = 4'd0;
    tick();
    bus_if.read_en = 1'b0;
    compared++;
    if (elem_count !== 5'd16 || bank_full !== 1'b1 || bus_if.data_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL full_fill: got cnt=%0d full=%b dv=%b, required cnt=16 full=1 dv=0",
               elem_count, bank_full, bus_if.data_valid);
    end
    compared++;
    if (a_bank[5*DW +: DW] !== 32'h105 || b_bank[15*DW +: DW] !== 32'h20F) begin
      mismatched++;
      $display("FAIL bank_slots: got a5=%h b15=%h, required a5=00000105 b15=0000020f",
               a_bank[5*DW +: DW], b_bank[15*DW +: DW]);
    end
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 6; i++) req(i, i);
    bus_if.read_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (elem_count !== 5'd6) begin
        mismatched++;
        $display("FAIL pause_hold: got cnt=%0d, required 6", elem_count);
      end
    end
    for (int i = 0; i < 10; i++) req((i + 9) % N, (i + 3) % N);
    bus_if.read_en = 1'b0;
    tick();
    compared++;
    if (elem_count !== 5'd16 || bank_full !== 1'b1 || a_bank[6*DW +: DW] !== rom_m[9]) begin
      mismatched++;
      $display("FAIL pause_full: got cnt=%0d full=%b a6=%h, required cnt=16 full=1 a6=%h",
               elem_count, bank_full, a_bank[6*DW +: DW], rom_m[9]);
    end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (a_bank[i*DW +: DW] !== exp_a[i] || b_bank[i*DW +: DW] !== exp_b[i]) begin
        mismatched++;
        $display("FAIL pause_bank slot %0d: got a=%h b=%h, required a=%h b=%h",
                 i, a_bank[i*DW +: DW], b_bank[i*DW +: DW], exp_a[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_full_ignore();
    for (int k = 0; k < 3; k++) begin
      bus_if.read_en = 1'b1;
      bus_if.rom_address = 4'd2;
      bus_if.ram_address = 4'd2;
      tick();
      compared++;
      if (bus_if.data_valid !== 1'b0 || elem_count !== 5'd16 || fetch_err !== EXP_ERR) begin
        mismatched++;
        $display("FAIL full_ignore: got dv=%b cnt=%0d err=%b, required dv=0 cnt=16 err=%b",
                 bus_if.data_valid, elem_count, fetch_err, EXP_ERR);
      end
    end
    bus_if.read_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      compared++;
      if (a_bank[i*DW +: DW] !== exp_a[i] || b_bank[i*DW +: DW] !== exp_b[i]) begin
        mismatched++;
        $display("FAIL full_bank slot %0d: got a=%h b=%h, required a=%h b=%h",
                 i, a_bank[i*DW +: DW], b_bank[i*DW +: DW], exp_a[i], exp_b[i]);
      end
    end
    consume = 1'b1;
    tick();
    consume = 1'b0;
    compared++;
    if (bank_full !== 1'b0 || elem_count !== 5'd0 || fetch_err !== EXP_ERR || a_bank[0 +: DW] !== exp_a[0]) begin
      mismatched++;
      $display("FAIL consume: got full=%b cnt=%0d err=%b a0=%h, required full=0 cnt=0 err=%b a0=%h",
               bank_full, elem_count, fetch_err, a_bank[0 +: DW], EXP_ERR, exp_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) req(15 - i, i);
    bus_if.read_en = 1'b0;
    tick();
    compared++;
    if (elem_count !== 5'd9) begin
      mismatched++;
      $display("FAIL mid_count: got cnt=%0d, required 9", elem_count);
    end
    reset = 1'b1;
    tick();
    compared++;
    if ({bus_if.a_data, bus_if.b_data, bus_if.data_valid, elem_count, bank_full, fetch_err} !== '0 ||
        a_bank !== '0 || b_bank !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: got a=%h b=%h dv=%b cnt=%0d full=%b err=%b, required all 0",
               bus_if.a_data, bus_if.b_data, bus_if.data_valid, elem_count, bank_full, fetch_err);
    end
    reset = 1'b0;
    slot = 0;
    for (int i = 0; i < N; i++) req(i, i);
    bus_if.read_en = 1'b0;
    tick();
    compared++;
    if (elem_count !== 5'd16 || a_bank[0 +: DW] !== rom_m[0] || b_bank[0 +: DW] !== ram_m[0]) begin
      mismatched++;
      $display("FAIL refill_slot0: got cnt=%0d a0=%h b0=%h, required cnt=16 a0=%h b0=%h",
               elem_count, a_bank[0 +: DW], b_bank[0 +: DW], rom_m[0], ram_m[0]);
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 5; i++) req(i, i);
    enable = 1'b0;
    bus_if.read_en = 1'b1;
    bus_if.rom_address = 4'd5;
    bus_if.ram_address = 4'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      compared++;
      if (elem_count !== 5'd4 || bus_if.data_valid !== 1'b1 || bus_if.a_data !== rom_m[4] || bank_full !== 1'b0) begin
        mismatched++;
        $display("FAIL enable_hold: got cnt=%0d dv=%b a=%h full=%b, required cnt=4 dv=1 a=%h full=0",
                 elem_count, bus_if.data_valid, bus_if.a_data, bank_full, rom_m[4]);
      end
    end
    enable = 1'b1;
    for (int i = 5; i < N; i++) req(i, i);
    bus_if.read_en = 1'b0;
    tick();
    compared++;
    if (elem_count !== 5'd16 || a_bank[4*DW +: DW] !== rom_m[4] || a_bank[5*DW +: DW] !== rom_m[5]) begin
      mismatched++;
      $display("FAIL enable_resume: got cnt=%0d a4=%h a5=%h, required cnt=16 a4=%h a5=%h",
               elem_count, a_bank[4*DW +: DW], a_bank[5*DW +: DW], rom_m[4], rom_m[5]);
    end
  endtask

  task automatic test_old_word();
    do_reset();
    bus_if.init_we = 1'b1;
    bus_if.init_sel = 1'b0;
    bus_if.init_addr = 4'd3;
    bus_if.init_data = 32'hDEAD;
    req(3, 3);
    bus_if.init_we = 1'b0;
    rom_m[3] = 32'hDEAD;
    compared++;
    if (bus_if.a_data !== 32'h103) begin
      mismatched++;
      $display("FAIL old_word: got a=%h, required 00000103", bus_if.a_data);
    end
    req(3, 3);
    bus_if.read_en = 1'b0;
    compared++;
    if (bus_if.a_data !== 32'hDEAD) begin
      mismatched++;
      $display("FAIL new_word: got a=%h, required 0000dead", bus_if.a_data);
    end
    tick();
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle_bus();
    test_reset();
    preload();
    test_full_fill();
    test_pause();
    test_full_ignore();
    test_reset_mid();
    test_enable();
    test_old_word();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/matrix_fetch_unit.md
Name: matrix_fetch_unit

Overview:
- Responder to the matrix-multiplier controller's read interface: serves `read_en` + `rom_address`/`ram_address` requests from two local operand memories.
- ROM side holds matrix A (weights); RAM side holds matrix B (activations).
- Returns one element pair per request with fixed 1-cycle latency and packs the returned elements into an A/B operand register bank.
- Flags the bank full once MAT_DIM*MAT_DIM elements have arrived, so the LOAD/MAC stages can consume it.

Parameters:
- DATA_WIDTH, 32, width of one matrix element.
- ADDR_WIDTH, 4, memory address width; each memory holds 2**ADDR_WIDTH words.
- MAT_DIM, 4, matrix dimension; the bank holds MAT_DIM*MAT_DIM elements per operand.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global advance; when low, all state and outputs hold.
- read_en  input  1  read request from the controller, one element pair per high cycle.
- rom_address  input  ADDR_WIDTH  matrix A read address.
- ram_address  input  ADDR_WIDTH  matrix B read address.
- init_we  input  1  memory preload write strobe.
- init_sel  input  1  preload target: 0 = ROM (A), 1 = RAM (B).
- init_addr  input  ADDR_WIDTH  preload address.
- init_data  input  DATA_WIDTH  preload data.
- consume  input  1  pulse from the LOAD stage: bank taken, release for refill.
- a_data  output  DATA_WIDTH  last returned A element.
- b_data  output  DATA_WIDTH  last returned B element.
- data_valid  output  1  a_data/b_data are valid this cycle.
- elem_count  output  $clog2(MAT_DIM*MAT_DIM)+1  number of elements written into the bank.
- bank_full  output  1  bank holds a complete A/B pair.
- a_bank  output  MAT_DIM*MAT_DIM*DATA_WIDTH  packed A bank; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_bank  output  MAT_DIM*MAT_DIM*DATA_WIDTH  packed B bank, same packing.
- fetch_err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (synchronous, overrides everything):
  - State goes to IDLE.
  - a_data, b_data, a_bank, b_bank, elem_count = 0.
  - data_valid, bank_full, fetch_err = 0.
  - Memory contents are not cleared.
- enable = 0: nothing updates, including preload writes. Preload (`init_we`) is otherwise accepted in any state.
- Read datapath:
  - read_en sampled high at edge N (state IDLE or FILL, enable = 1) → mem[rom_address] and mem[ram_address] appear on a_data/b_data with data_valid = 1 after edge N+1.
  - Latency is exactly 1 cycle; back-to-back requests give back-to-back data.
  - Preload write and read to the same address in the same cycle → read returns the OLD word.
- On each data_valid cycle in FILL, the element is written to bank slot elem_count and elem_count increments.
- State machine:
  - IDLE: read_en → FILL (the request is served).
  - FILL: read_en low pauses the fill; elem_count and bank contents hold. When the MAT_DIM*MAT_DIM-th element is written (16 by default), go to FULL; bank_full = 1 in the same cycle elem_count reaches 16.
  - FULL:
    - read_en is ignored: no memory read, data_valid = 0, bank unchanged.
    - consume → IDLE at the next edge: bank_full = 0, elem_count = 0.
    - Bank contents are retained until overwritten.
  - consume in IDLE or FILL is ignored.
- A request issued on the cycle the 16th element returns is dropped and not counted.
- Address wrap: addresses are taken modulo 2**ADDR_WIDTH with no error.
- Reset mid-fill: partial bank is discarded; the next fill starts at slot 0.

Optional Feature:
- Macro FETCH_ERR_EN.
- Defined:
  - fetch_err sets on read_en while FULL.
  - fetch_err sets on consume while not FULL.
  - It is sticky until reset.
- Undefined: fetch_err is tied to 0 and the error logic is absent. Functional behaviour is otherwise identical.

Test Plan:
- Preload ROM[i] = 0x100+i and RAM[i] = 0x200+i (i = 0..15); reset; read_en high 16 cycles with addresses 0..15 → data_valid from cycle 2 to 17; a_data = 0x100..0x10F; elem_count reaches 16 with bank_full = 1; a_bank slot 5 = 0x105, b_bank slot 15 = 0x20F.
- Read_en high 6 cycles, low 4, high 10 → elem_count holds at 6 during the gap; bank_full asserts after the 16th return; slot 6 = element from the first post-gap address.
- Bank FULL, read_en high 3 cycles → data_valid stays 0 and the bank is unchanged; with FETCH_ERR_EN, fetch_err = 1 and stays 1. Then consume → bank_full = 0 and elem_count = 0 next cycle.
- Reset asserted after 9 elements → all outputs 0 next cycle; a new 16-read fill places address 0 data in slot 0.
- enable low for 5 cycles mid-fill with read_en high → no outputs change; fill resumes exactly where it stopped.
- init_we to ROM[3] = 0xDEAD concurrent with a read of ROM[3] (old 0x103) → a_data = 0x103; the next read of address 3 returns 0xDEAD.
